// File: rtl/irq_ack_sequencer_if.sv
// irq_ack_sequencer_if: CPU acknowledge / slot interrupt signal bundle
interface irq_ack_sequencer_if #(parameter int NUM_IRQ_SLOTS = 4);
    logic [2*NUM_IRQ_SLOTS-1:0] slot_int_n;
    logic [1:0]                 cpu_ack_n;
    logic                       int_ack_mode_en;
    logic [2*NUM_IRQ_SLOTS-1:0] slot_int_ack_n;
    logic                       ack_busy;
    logic [2:0]                 ack_slot;
    logic                       ack_chan;
    logic                       ack_done;
    logic                       ack_timeout;
    logic                       ack_noclaim;
    modport master (
        output slot_int_n, cpu_ack_n, int_ack_mode_en,
        input  slot_int_ack_n, ack_busy, ack_slot, ack_chan, ack_done, ack_timeout, ack_noclaim
    );
    modport slave (
        input  slot_int_n, cpu_ack_n, int_ack_mode_en,
        output slot_int_ack_n, ack_busy, ack_slot, ack_chan, ack_done, ack_timeout, ack_noclaim
    );
endinterface

// File: rtl/irq_ack_sequencer.sv
// irq_ack_sequencer: Mode-2 interrupt acknowledge arbiter with per-channel round-robin
module irq_ack_sequencer #(
    parameter int NUM_IRQ_SLOTS = 4,
    parameter int ACK_TIMEOUT   = 255
) (
    input logic clk,
    input logic rst,
    irq_ack_sequencer_if.slave bus
);
    localparam int W = 2*NUM_IRQ_SLOTS;
    typedef enum logic [1:0] {IDLE, ARB, GRANT, WAIT_REL} state_t;
    state_t state_q, state_d;
    logic [W-1:0] slot_int_ack_n_q, slot_int_ack_n_d;
    logic [2:0] ack_slot_q, ack_slot_d;
    logic ack_chan_q, ack_chan_d;
    logic ack_done_q, ack_done_d;
    logic ack_timeout_q, ack_timeout_d;
    logic ack_noclaim_q, ack_noclaim_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0][2:0] rr_q, rr_d;
    logic [NUM_IRQ_SLOTS-1:0] claim;
    logic found;
    logic [2:0] pick;
    // Round-robin search: first claimant strictly after the channel's pointer, wrapping
    always_comb begin
        found = 1'b0;
        pick = 3'd0;
        for (int s = 0; s < NUM_IRQ_SLOTS; s++) claim[s] = ~bus.slot_int_n[s*2 + int'(ack_chan_q)];
        for (int i = 1; i <= NUM_IRQ_SLOTS; i++) begin
            if (!found && claim[(int'(rr_q[ack_chan_q]) + i) % NUM_IRQ_SLOTS]) begin
                found = 1'b1;
                pick = 3'((int'(rr_q[ack_chan_q]) + i) % NUM_IRQ_SLOTS);
            end
        end
    end
    // Next state, pulses, pointer update; the ack line is held low only while GRANT persists,
    // so it drops on the same edge that leaves GRANT
    always_comb begin
        state_d = state_q;
        ack_slot_d = ack_slot_q;
        ack_chan_d = ack_chan_q;
        timer_d = timer_q;
        rr_d = rr_q;
        ack_done_d = 1'b0;
        ack_timeout_d = 1'b0;
        ack_noclaim_d = 1'b0;
        case (state_q)
            IDLE: if (bus.int_ack_mode_en && bus.cpu_ack_n != 2'b11) begin
                ack_chan_d = bus.cpu_ack_n[0];
                state_d = ARB;
            end
            ARB: if (!found) begin
                ack_noclaim_d = 1'b1;
                state_d = WAIT_REL;
            end else begin
                ack_slot_d = pick;
                timer_d = 16'd0;
                state_d = GRANT;
            end
            GRANT: begin
                timer_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
                if (bus.cpu_ack_n[ack_chan_q]) begin
                    ack_done_d = 1'b1;
                    rr_d[ack_chan_q] = ack_slot_q;
                    state_d = IDLE;
                end else if (timer_q >= 16'(ACK_TIMEOUT)) begin
                    ack_timeout_d = 1'b1;
                    rr_d[ack_chan_q] = ack_slot_q;
                    state_d = WAIT_REL;
                end else if (!bus.int_ack_mode_en) begin
                    ack_timeout_d = 1'b1;
                    state_d = WAIT_REL;
                end
            end
            default: if (&bus.cpu_ack_n) state_d = IDLE;
        endcase
        slot_int_ack_n_d = {W{1'b1}};
        if (state_q == GRANT && state_d == GRANT) slot_int_ack_n_d[int'(ack_slot_q)*2 + int'(ack_chan_q)] = 1'b0;
    end
    // State register with asynchronous reset so the ack line releases immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            slot_int_ack_n_q <= {W{1'b1}};
            ack_slot_q <= 3'd0;
            ack_chan_q <= 1'b0;
            ack_done_q <= 1'b0;
            ack_timeout_q <= 1'b0;
            ack_noclaim_q <= 1'b0;
            timer_q <= 16'd0;
            rr_q <= {2{3'(NUM_IRQ_SLOTS-1)}};
        end else begin
            state_q <= state_d;
            slot_int_ack_n_q <= slot_int_ack_n_d;
            ack_slot_q <= ack_slot_d;
            ack_chan_q <= ack_chan_d;
            ack_done_q <= ack_done_d;
            ack_timeout_q <= ack_timeout_d;
            ack_noclaim_q <= ack_noclaim_d;
            timer_q <= timer_d;
            rr_q <= rr_d;
        end
    end
    assign bus.slot_int_ack_n = slot_int_ack_n_q;
    assign bus.ack_busy = state_q != IDLE;
    assign bus.ack_slot = ack_slot_q;
    assign bus.ack_chan = ack_chan_q;
    assign bus.ack_done = ack_done_q;
    assign bus.ack_timeout = ack_timeout_q;
    assign bus.ack_noclaim = ack_noclaim_q;
endmodule

// File: tb/tb_irq_ack_sequencer.sv
// tb_irq_ack_sequencer: directed checks of arbitration, latency, timeout, abort and reset
module tb_irq_ack_sequencer;
    logic clk, rst;
    int n_cmp = 0;
    int n_err = 0;
    int low_cnt, tmo_cnt;
    irq_ack_sequencer_if #(.NUM_IRQ_SLOTS(4)) bus();
    irq_ack_sequencer #(.NUM_IRQ_SLOTS(4), .ACK_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic xact(input string tag, input logic [2:0] slot, input logic [7:0] sian);
        bus.cpu_ack_n = 2'b01;
        tick(); tick(); tick();
        chk({tag, "_sian"}, 32'(bus.slot_int_ack_n), 32'(sian));
        chk({tag, "_slot"}, 32'(bus.ack_slot), 32'(slot));
        chk({tag, "_chan"}, 32'(bus.ack_chan), 32'd1);
        bus.cpu_ack_n = 2'b11;
        tick();
        chk({tag, "_done"}, 32'(bus.ack_done), 32'd1);
        chk({tag, "_rel"}, 32'(bus.slot_int_ack_n), 32'hFF);
    endtask
    initial begin
        rst = 1'b1;
        bus.slot_int_n = 8'hFF;
        bus.cpu_ack_n = 2'b11;
        bus.int_ack_mode_en = 1'b0;
        #12;
        chk("rst_sian", 32'(bus.slot_int_ack_n), 32'hFF);
        chk("rst_busy", 32'(bus.ack_busy), 32'd0);
        chk("rst_slot", 32'(bus.ack_slot), 32'd0);
        chk("rst_chan", 32'(bus.ack_chan), 32'd0);
        chk("rst_pulses", 32'({bus.ack_done, bus.ack_timeout, bus.ack_noclaim}), 32'd0);
        rst = 1'b0;
        tick();
        // basic grant: slot 2 on channel 0
        bus.int_ack_mode_en = 1'b1;
        bus.slot_int_n = 8'hEF;
        bus.cpu_ack_n = 2'b10;
        tick();
        chk("b_arb_busy", 32'(bus.ack_busy), 32'd1);
        chk("b_arb_sian", 32'(bus.slot_int_ack_n), 32'hFF);
        tick();
        chk("b_g0_sian", 32'(bus.slot_int_ack_n), 32'hFF);
        tick();
        chk("b_g1_sian", 32'(bus.slot_int_ack_n), 32'hEF);
        tick(); tick();
        chk("b_g3_sian", 32'(bus.slot_int_ack_n), 32'hEF);
        chk("b_slot", 32'(bus.ack_slot), 32'd2);
        chk("b_chan", 32'(bus.ack_chan), 32'd0);
        bus.cpu_ack_n = 2'b11;
        tick();
        chk("b_rel_sian", 32'(bus.slot_int_ack_n), 32'hFF);
        chk("b_done", 32'(bus.ack_done), 32'd1);
        chk("b_idle", 32'(bus.ack_busy), 32'd0);
        tick();
        chk("b_done_pulse", 32'(bus.ack_done), 32'd0);
        chk("b_hold_slot", 32'(bus.ack_slot), 32'd2);
        // round robin on channel 1: slots 0,1,3 claim
        bus.slot_int_n = 8'h75;
        xact("rr0", 3'd0, 8'hFD);
        xact("rr1", 3'd1, 8'hF7);
        xact("rr2", 3'd3, 8'h7F);
        xact("rr3", 3'd0, 8'hFD);
        // timeout: slot 1 channel 0, ack held 20 cycles
        bus.slot_int_n = 8'hFB;
        bus.cpu_ack_n = 2'b10;
        tick(); tick();
        low_cnt = 0;
        tmo_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (bus.slot_int_ack_n == 8'hFB) low_cnt++;
            if (bus.ack_timeout) tmo_cnt++;
            if (i == 0) chk("t_slot", 32'(bus.ack_slot), 32'd1);
            if (i == 17) chk("t_busy_held", 32'(bus.ack_busy), 32'd1);
        end
        chk("t_low_cycles", 32'(low_cnt), 32'd4);
        chk("t_pulses", 32'(tmo_cnt), 32'd1);
        bus.cpu_ack_n = 2'b11;
        tick();
        chk("t_idle", 32'(bus.ack_busy), 32'd0);
        chk("t_no_done", 32'(bus.ack_done), 32'd0);
        // no claimant with both acks low
        bus.slot_int_n = 8'hFF;
        bus.cpu_ack_n = 2'b00;
        tick();
        chk("n_chan", 32'(bus.ack_chan), 32'd0);
        tick();
        chk("n_noclaim", 32'(bus.ack_noclaim), 32'd1);
        chk("n_sian", 32'(bus.slot_int_ack_n), 32'hFF);
        tick();
        chk("n_pulse", 32'(bus.ack_noclaim), 32'd0);
        chk("n_wait", 32'(bus.ack_busy), 32'd1);
        bus.cpu_ack_n = 2'b11;
        tick();
        chk("n_idle", 32'(bus.ack_busy), 32'd0);
        // mode disabled: acks ignored
        bus.int_ack_mode_en = 1'b0;
        bus.slot_int_n = 8'hEF;
        bus.cpu_ack_n = 2'b00; tick();
        chk("m_busy0", 32'(bus.ack_busy), 32'd0);
        bus.cpu_ack_n = 2'b01; tick();
        chk("m_busy1", 32'(bus.ack_busy), 32'd0);
        bus.cpu_ack_n = 2'b10; tick();
        chk("m_busy2", 32'(bus.ack_busy), 32'd0);
        bus.cpu_ack_n = 2'b11; tick();
        // mode dropped mid-grant: slot 2 picked after pointer 1
        bus.int_ack_mode_en = 1'b1;
        bus.cpu_ack_n = 2'b10;
        tick(); tick(); tick();
        chk("a_sian", 32'(bus.slot_int_ack_n), 32'hEF);
        bus.int_ack_mode_en = 1'b0;
        tick();
        chk("a_rel", 32'(bus.slot_int_ack_n), 32'hFF);
        chk("a_tmo", 32'(bus.ack_timeout), 32'd1);
        chk("a_busy", 32'(bus.ack_busy), 32'd1);
        bus.cpu_ack_n = 2'b11;
        tick();
        chk("a_idle", 32'(bus.ack_busy), 32'd0);
        // reset mid-grant: pointer 0 was left at 1, so slot 2 wins before reset
        bus.int_ack_mode_en = 1'b1;
        bus.slot_int_n = 8'hAA;
        bus.cpu_ack_n = 2'b10;
        tick(); tick(); tick();
        chk("r_sian", 32'(bus.slot_int_ack_n), 32'hEF);
        #2 rst = 1'b1;
        #1;
        chk("r_async", 32'(bus.slot_int_ack_n), 32'hFF);
        chk("r_busy", 32'(bus.ack_busy), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("r_regrant", 32'(bus.slot_int_ack_n), 32'hFE);
        chk("r_slot", 32'(bus.ack_slot), 32'd0);
        bus.cpu_ack_n = 2'b11;
        tick();
        chk("r_done", 32'(bus.ack_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
